// File: rtl/npc_pkg.sv
// Shared NPC core types and constants.
// Holds the writeback FSM states and the writeback stage entry layout.
package npc_pkg;

    localparam int XLEN = 32;
    localparam int RAW  = 5;

    localparam logic [RAW-1:0] REG_ZERO = 5'd0;
    localparam logic [RAW-1:0] REG_A0   = 5'd10;

    typedef enum logic [1:0] {
        IDLE,
        FULL,
        HALT
    } wbu_state_t;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] result;
        logic [RAW-1:0]  rd;
        logic            wen;
        logic            ebreak;
    } wb_entry_t;

endpackage

// File: rtl/regfile.sv
// General-purpose register file: 2 async read ports, 1 sync write port,
// synchronous clear, x0 hardwired to zero, out-of-range addresses read 0.
// Ports: clk, rst, we/waddr/wdata (write), raddr1/2 -> rdata1/2, a0 (x10 tap).
module regfile
    import npc_pkg::REG_A0;
#(
    parameter int XLEN    = 32,
    parameter int NR_REGS = 32,
    parameter int RAW     = 5
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            we,
    input  logic [RAW-1:0]  waddr,
    input  logic [XLEN-1:0] wdata,
    input  logic [RAW-1:0]  raddr1,
    input  logic [RAW-1:0]  raddr2,
    output logic [XLEN-1:0] rdata1,
    output logic [XLEN-1:0] rdata2,
    output logic [XLEN-1:0] a0
);

    logic [XLEN-1:0] regs [NR_REGS];

    // Addresses that map onto a real, writable register.
    function automatic logic live(input logic [RAW-1:0] a);
        return (a != '0) && (32'(a) < NR_REGS);
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NR_REGS; i++) begin
                regs[i] <= '0;
            end
        end else if (we && live(waddr)) begin
            regs[waddr] <= wdata;
        end
    end

    assign rdata1 = live(raddr1) ? regs[raddr1] : '0;
    assign rdata2 = live(raddr2) ? regs[raddr2] : '0;
    assign a0     = regs[REG_A0];

endmodule

// File: rtl/wbu.sv
// Writeback stage: one-entry buffer that commits ALU results to the
// register file, bypasses the in-flight write to decode reads, counts
// retired instructions and halts on a committed ebreak.
// Ports: in_* handshake/payload from execute, rs1/rs2 read ports,
// commit_valid/commit_pc, retire_cnt, halt/halt_code.
module wbu
    import npc_pkg::wbu_state_t, npc_pkg::IDLE, npc_pkg::FULL,
           npc_pkg::HALT, npc_pkg::wb_entry_t, npc_pkg::REG_ZERO;
#(
    parameter int XLEN    = npc_pkg::XLEN,
    parameter int NR_REGS = 32,
    parameter int RAW     = npc_pkg::RAW
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] in_pc,
    input  logic [XLEN-1:0] in_result,
    input  logic [RAW-1:0]  in_rd,
    input  logic            in_wen,
    input  logic            in_ebreak,
    input  logic [RAW-1:0]  rs1_addr,
    input  logic [RAW-1:0]  rs2_addr,
    output logic [XLEN-1:0] rs1_data,
    output logic [XLEN-1:0] rs2_data,
    output logic            commit_valid,
    output logic [XLEN-1:0] commit_pc,
    output logic [63:0]     retire_cnt,
    output logic            halt,
    output logic [XLEN-1:0] halt_code
);

    wbu_state_t      state_q;
    wbu_state_t      state_d;
    wb_entry_t       ent_q;
    logic [63:0]     retire_cnt_q;
    logic            accept;
    logic            wr_en;
    logic            byp_ok;
    logic [XLEN-1:0] rf_rdata1;
    logic [XLEN-1:0] rf_rdata2;
    logic [XLEN-1:0] rf_a0;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        in_ready     = 1'b0;
        commit_valid = 1'b0;
        commit_pc    = '0;
        halt         = 1'b0;
        accept       = 1'b0;
        unique case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                accept   = in_valid;
                if (in_valid) begin
                    state_d = FULL;
                end
            end
            FULL: begin
                commit_valid = 1'b1;
                commit_pc    = ent_q.pc;
                // A buffered ebreak closes the door to new work.
                in_ready     = !ent_q.ebreak;
                accept       = in_valid && !ent_q.ebreak;
                if (ent_q.ebreak) begin
                    state_d = HALT;
                end else if (in_valid) begin
                    state_d = FULL;
                end else begin
                    state_d = IDLE;
                end
            end
            HALT: begin
                halt = 1'b1;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ent_q <= '0;
        end else if (accept) begin
            ent_q <= '{
                pc:     in_pc,
                result: in_result,
                rd:     in_rd,
                wen:    in_wen,
                ebreak: in_ebreak
            };
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            retire_cnt_q <= '0;
        end else if (commit_valid) begin
            retire_cnt_q <= retire_cnt_q + 64'd1;
        end
    end

    assign retire_cnt = retire_cnt_q;

    assign wr_en = commit_valid && ent_q.wen;

    // Only forward writes that will actually land in the array.
    assign byp_ok = wr_en && (ent_q.rd != REG_ZERO)
                 && (32'(ent_q.rd) < NR_REGS);

    regfile #(
        .XLEN    (XLEN),
        .NR_REGS (NR_REGS),
        .RAW     (RAW)
    ) u_rf (
        .clk    (clk),
        .rst    (rst),
        .we     (wr_en),
        .waddr  (ent_q.rd),
        .wdata  (ent_q.result),
        .raddr1 (rs1_addr),
        .raddr2 (rs2_addr),
        .rdata1 (rf_rdata1),
        .rdata2 (rf_rdata2),
        .a0     (rf_a0)
    );

    assign rs1_data = (byp_ok && rs1_addr == ent_q.rd) ? ent_q.result
                                                        : rf_rdata1;
    assign rs2_data = (byp_ok && rs2_addr == ent_q.rd) ? ent_q.result
                                                        : rf_rdata2;

    assign halt_code = halt ? rf_a0 : '0;

endmodule

// File: tb/tb_wbu.sv
// Self-checking bench for wbu: directed vector table plus hand-written
// sequences for halt, mid-operation reset and counter wrap.
module tb_wbu;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_pc;
    logic [31:0] in_result;
    logic [4:0]  in_rd;
    logic        in_wen;
    logic        in_ebreak;
    logic [4:0]  rs1_addr;
    logic [4:0]  rs2_addr;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic        commit_valid;
    logic [31:0] commit_pc;
    logic [63:0] retire_cnt;
    logic        halt;
    logic [31:0] halt_code;

    int errors = 0;
    int checks = 0;

    wbu dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_pc        (in_pc),
        .in_result    (in_result),
        .in_rd        (in_rd),
        .in_wen       (in_wen),
        .in_ebreak    (in_ebreak),
        .rs1_addr     (rs1_addr),
        .rs2_addr     (rs2_addr),
        .rs1_data     (rs1_data),
        .rs2_data     (rs2_data),
        .commit_valid (commit_valid),
        .commit_pc    (commit_pc),
        .retire_cnt   (retire_cnt),
        .halt         (halt),
        .halt_code    (halt_code)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        v;
        logic [31:0] pc;
        logic [31:0] res;
        logic [4:0]  rd;
        logic        wen;
        logic [4:0]  a1;
        logic [4:0]  a2;
        logic        e_rdy;
        logic        e_cv;
        logic [31:0] e_pc;
        logic [31:0] e_d1;
        logic [31:0] e_d2;
        logic [63:0] e_cnt;
    } vec_t;

    vec_t tv[$];

    function automatic vec_t mk(
        input logic v, input logic [31:0] pc, input logic [31:0] res,
        input logic [4:0] rd, input logic wen,
        input logic [4:0] a1, input logic [4:0] a2,
        input logic e_rdy, input logic e_cv, input logic [31:0] e_pc,
        input logic [31:0] e_d1, input logic [31:0] e_d2,
        input logic [63:0] e_cnt);
        vec_t t;
        t.v = v; t.pc = pc; t.res = res; t.rd = rd; t.wen = wen;
        t.a1 = a1; t.a2 = a2; t.e_rdy = e_rdy; t.e_cv = e_cv;
        t.e_pc = e_pc; t.e_d1 = e_d1; t.e_d2 = e_d2; t.e_cnt = e_cnt;
        return t;
    endfunction

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [31:0] pc,
                         input logic [31:0] res, input logic [4:0] rd,
                         input logic wen, input logic eb);
        in_valid  = v;
        in_pc     = pc;
        in_result = res;
        in_rd     = rd;
        in_wen    = wen;
        in_ebreak = eb;
    endtask

    initial begin
        rst = 1'b1;
        drive(1'b0, '0, '0, '0, 1'b0, 1'b0);
        rs1_addr = 5'd10;
        rs2_addr = 5'd0;

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("reset in_ready", 64'(in_ready), 64'd1);
        chk("reset commit_valid", 64'(commit_valid), 64'd0);
        chk("reset commit_pc", 64'(commit_pc), 64'd0);
        chk("reset retire_cnt", retire_cnt, 64'd0);
        chk("reset halt", 64'(halt), 64'd0);
        chk("reset halt_code", 64'(halt_code), 64'd0);
        chk("reset x10", 64'(rs1_data), 64'd0);

        // v pc res rd wen a1 a2 | rdy cv pc d1 d2 cnt
        tv.push_back(mk(1, 32'h100, 32'h12345678, 5, 1, 5, 0,
                        1, 0, 0, 0, 0, 0));
        tv.push_back(mk(0, 0, 0, 0, 0, 5, 5,
                        1, 1, 32'h100, 32'h12345678, 32'h12345678, 0));
        tv.push_back(mk(0, 0, 0, 0, 0, 5, 0,
                        1, 0, 0, 32'h12345678, 0, 1));
        tv.push_back(mk(1, 32'h104, 32'hDEADBEEF, 0, 1, 0, 0,
                        1, 0, 0, 0, 0, 1));
        tv.push_back(mk(0, 0, 0, 0, 0, 0, 0,
                        1, 1, 32'h104, 0, 0, 1));
        tv.push_back(mk(0, 0, 0, 0, 0, 0, 5,
                        1, 0, 0, 0, 32'h12345678, 2));
        tv.push_back(mk(1, 32'h80000000, 1, 1, 1, 1, 2,
                        1, 0, 0, 0, 0, 2));
        tv.push_back(mk(1, 32'h80000004, 2, 2, 1, 1, 2,
                        1, 1, 32'h80000000, 1, 0, 2));
        tv.push_back(mk(1, 32'h80000008, 3, 3, 1, 1, 2,
                        1, 1, 32'h80000004, 1, 2, 3));
        tv.push_back(mk(1, 32'h8000000C, 4, 4, 1, 3, 4,
                        1, 1, 32'h80000008, 3, 0, 4));
        tv.push_back(mk(0, 0, 0, 0, 0, 4, 3,
                        1, 1, 32'h8000000C, 4, 3, 5));
        tv.push_back(mk(0, 0, 0, 0, 0, 4, 1,
                        1, 0, 0, 4, 1, 6));
        tv.push_back(mk(1, 32'h200, 32'h55, 6, 0, 6, 0,
                        1, 0, 0, 0, 0, 6));
        tv.push_back(mk(0, 0, 0, 0, 0, 6, 6,
                        1, 1, 32'h200, 0, 0, 6));
        tv.push_back(mk(0, 0, 0, 0, 0, 6, 0,
                        1, 0, 0, 0, 0, 7));

        for (int i = 0; i < tv.size(); i++) begin
            @(negedge clk);
            drive(tv[i].v, tv[i].pc, tv[i].res, tv[i].rd,
                  tv[i].wen, 1'b0);
            rs1_addr = tv[i].a1;
            rs2_addr = tv[i].a2;
            #1;
            chk($sformatf("v%0d in_ready", i), 64'(in_ready),
                64'(tv[i].e_rdy));
            chk($sformatf("v%0d commit_valid", i), 64'(commit_valid),
                64'(tv[i].e_cv));
            chk($sformatf("v%0d commit_pc", i), 64'(commit_pc),
                64'(tv[i].e_pc));
            chk($sformatf("v%0d rs1_data", i), 64'(rs1_data),
                64'(tv[i].e_d1));
            chk($sformatf("v%0d rs2_data", i), 64'(rs2_data),
                64'(tv[i].e_d2));
            chk($sformatf("v%0d retire_cnt", i), retire_cnt,
                tv[i].e_cnt);
            chk($sformatf("v%0d halt", i), 64'(halt), 64'd0);
        end

        // Halt: x10 <- 7, then an ebreak that itself writes x12
        @(negedge clk);
        drive(1'b1, 32'h300, 32'h7, 5'd10, 1'b1, 1'b0);
        @(negedge clk);
        drive(1'b1, 32'h304, 32'h77, 5'd12, 1'b1, 1'b1);
        #1;
        chk("a0 write commit_pc", 64'(commit_pc), 64'h300);
        chk("a0 write in_ready", 64'(in_ready), 64'd1);
        @(negedge clk);
        drive(1'b1, 32'h308, 32'h99, 5'd11, 1'b1, 1'b0);
        rs1_addr = 5'd12;
        rs2_addr = 5'd10;
        #1;
        chk("ebreak in_ready", 64'(in_ready), 64'd0);
        chk("ebreak commit_valid", 64'(commit_valid), 64'd1);
        chk("ebreak commit_pc", 64'(commit_pc), 64'h304);
        chk("ebreak bypass x12", 64'(rs1_data), 64'h77);
        chk("ebreak x10", 64'(rs2_data), 64'h7);
        chk("ebreak halt low", 64'(halt), 64'd0);
        @(negedge clk);
        #1;
        chk("halt", 64'(halt), 64'd1);
        chk("halt_code", 64'(halt_code), 64'h7);
        chk("halt in_ready", 64'(in_ready), 64'd0);
        chk("halt commit_valid", 64'(commit_valid), 64'd0);
        chk("halt retire_cnt", retire_cnt, 64'd9);
        chk("halt x12", 64'(rs1_data), 64'h77);
        @(negedge clk);
        rs1_addr = 5'd11;
        #1;
        chk("halt2 commit_valid", 64'(commit_valid), 64'd0);
        chk("halt2 x11 unwritten", 64'(rs1_data), 64'd0);
        chk("halt2 retire_cnt", retire_cnt, 64'd9);
        chk("halt2 halt", 64'(halt), 64'd1);

        // Reset out of HALT
        @(negedge clk);
        drive(1'b0, '0, '0, '0, 1'b0, 1'b0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        rs1_addr = 5'd10;
        rs2_addr = 5'd12;
        #1;
        chk("rst2 in_ready", 64'(in_ready), 64'd1);
        chk("rst2 halt", 64'(halt), 64'd0);
        chk("rst2 halt_code", 64'(halt_code), 64'd0);
        chk("rst2 retire_cnt", retire_cnt, 64'd0);
        chk("rst2 x10", 64'(rs1_data), 64'd0);
        chk("rst2 x12", 64'(rs2_data), 64'd0);

        // Reset while the x3 write is in FULL
        @(negedge clk);
        drive(1'b1, 32'h400, 32'hAA, 5'd3, 1'b1, 1'b0);
        @(negedge clk);
        drive(1'b0, '0, '0, '0, 1'b0, 1'b0);
        rst = 1'b1;
        rs1_addr = 5'd3;
        #1;
        chk("midrst commit_valid", 64'(commit_valid), 64'd1);
        chk("midrst bypass", 64'(rs1_data), 64'hAA);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("midrst x3", 64'(rs1_data), 64'd0);
        chk("midrst retire_cnt", retire_cnt, 64'd0);
        chk("midrst commit_valid", 64'(commit_valid), 64'd0);
        chk("midrst in_ready", 64'(in_ready), 64'd1);
        @(negedge clk);
        #1;
        chk("midrst idle", 64'(commit_valid), 64'd0);
        chk("midrst x3 again", 64'(rs1_data), 64'd0);

        // Counter wrap
        @(negedge clk);
        drive(1'b1, 32'h500, 32'h0, 5'd0, 1'b0, 1'b0);
        force dut.retire_cnt_q = '1;
        #1;
        chk("wrap preload", retire_cnt, 64'hFFFF_FFFF_FFFF_FFFF);
        @(negedge clk);
        drive(1'b0, '0, '0, '0, 1'b0, 1'b0);
        release dut.retire_cnt_q;
        #1;
        chk("wrap commit_valid", 64'(commit_valid), 64'd1);
        chk("wrap commit_pc", 64'(commit_pc), 64'h500);
        chk("wrap held", retire_cnt, 64'hFFFF_FFFF_FFFF_FFFF);
        @(negedge clk);
        #1;
        chk("wrap to zero", retire_cnt, 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/wbu.md
# wbu

Writeback stage of the single-issue NPC core, directly downstream of the execute ALU. Accepts one ALU result per cycle over a valid/ready handshake and holds it in a one-entry stage register. Commits it to the integrated 32×32 general-purpose register file and serves the decode stage's two combinational read ports with same-cycle write bypass. Also counts retired instructions and halts the core on a committed `ebreak`.

## Interface
- `XLEN`, default 32: data and PC width.
- `NR_REGS`, default 32: number of architectural registers. Must be 16 or 32.
- `RAW`, default 5: register address width.
- `clk` input 1: the single clock.
- `rst` input 1: synchronous, active-high reset.
- `in_valid` input 1: execute stage presents a result.
- `in_ready` output 1: stage can accept this cycle.
- `in_pc` input XLEN: PC of the instruction.
- `in_result` input XLEN: ALU result.
- `in_rd` input RAW: destination register.
- `in_wen` input 1: instruction writes `rd`.
- `in_ebreak` input 1: instruction is `ebreak`.
- `rs1_addr`, `rs2_addr` input RAW each: decode read addresses.
- `rs1_data`, `rs2_data` output XLEN each: read data, combinational.
- `commit_valid` output 1: an entry retires this cycle.
- `commit_pc` output XLEN: PC of the retiring entry.
- `retire_cnt` output 64: retired-instruction count.
- `halt` output 1: core halted.
- `halt_code` output XLEN: value of x10 (a0) at halt.

## Operation
- States: IDLE (buffer empty), FULL (buffer holds an entry), HALT.
- IDLE: `in_valid` moves to FULL and captures pc, result, rd, wen, and ebreak.
- FULL: the entry commits this cycle.
  - If the entry's ebreak flag is set, the next state is HALT; any concurrent input is not accepted.
  - Otherwise, if `in_valid`, the new entry is captured and the state stays FULL (back-to-back throughput 1/cycle).
  - Otherwise the next state is IDLE.
- HALT: terminal until `rst`. No accepts, no writes.
- `in_ready` = (state != HALT) and not (state == FULL and buffered ebreak).
- Commit, in FULL:
  - `commit_valid` = 1 and `commit_pc` = buffered pc.
  - Register file writes `result` to `rd` at the clock edge ending the cycle, if `wen` and `rd` != 0.
  - `retire_cnt` increments by 1 at the same edge and wraps modulo 2^64.
- Register file reads:
  - Address 0 always reads 0. Writes to x0 are dropped.
  - Address >= `NR_REGS` reads 0 and is never written.
- Bypass: in FULL with `wen`, a read whose address equals buffered `rd` (≠0) returns the buffered result, not the stale array value. Applies to both ports independently.
- `halt` = (state == HALT). `halt_code` = register x10, read from the array after the final commit. The ebreak entry's own write, if any, is included.

## Timing
- Reset values:
  - state IDLE.
  - `in_ready` 1, `commit_valid` 0, `commit_pc` 0.
  - `retire_cnt` 0, `halt` 0, `halt_code` 0.
  - All registers 0.
- Latency: accept at edge T; `commit_valid` is high in cycle T..T+1; register write and count update occur at edge T+1.
- `rs*_data` are purely combinational from the address, array, and buffer. Zero-cycle read.
- `in_ready` depends only on state and buffer, never on `in_valid`.
- Reset mid-operation:
  - Buffered entry is discarded; no write, no count.
  - Array is cleared and the state returns to IDLE on that edge.
- Simultaneous commit and accept in FULL: the old entry writes while the new one is captured, with no bubble.

## Structure
- Shared package `npc_pkg`:
  - Constants `XLEN`, `RAW`, `REG_ZERO`=0, `REG_A0`=10.
  - Enum `wbu_state_t` {IDLE, FULL, HALT}.
  - Struct `wb_entry_t` {pc, result, rd, wen, ebreak}.
- Sub-module `regfile`:
  - 2 async read ports, 1 sync write port, synchronous clear, x0 hardwired.
  - Bypass logic lives in `wbu`, not in `regfile`.

## Test plan
- Reset, then send result 0x12345678 with rd=5, wen=1 → `commit_valid` one cycle later with matching pc. `rs1_addr`=5 reads 0x12345678 during the commit cycle (bypass) and after it. `retire_cnt`=1.
- Write 0xDEADBEEF to rd=0 → `rs1_data`/`rs2_data` at address 0 stay 0. Count still increments.
- Four back-to-back valids with pcs 0x80000000..0x8000000C → `in_ready` held 1 throughout. Four consecutive `commit_valid` cycles in order. `retire_cnt`=4.
- Write 7 to x10, then `ebreak` → `halt`=1 the cycle after the ebreak commit. `halt_code`=7. `in_ready`=0. A later `in_valid` causes no commit and no write.
- Assert `rst` in the FULL cycle of a write 0xAA to x3 → x3 reads 0 afterwards. `retire_cnt`=0, state IDLE.
- Preload `retire_cnt` to 2^64−1 via force, then commit one entry → counter reads 0.
